// File: rtl/transmitter_burst_driver_pkg.sv
// Shared definitions for the ultrasonic transmitter burst driver.
//   state_t            : top-level FSM encoding (IDLE=0, RUN=1, DONE=2)
//   TX_HALF_PERIOD_50M : carrier half-period in clk_in cycles for a 50 MHz
//                        clock and a 40 kHz carrier
package transmitter_burst_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int TX_HALF_PERIOD_50M = 625;

endpackage

// File: rtl/transmitter_burst_driver_channel.sv
// One transmitter channel: waits its start delay, then drives N carrier
// periods (high half first) on its pin.
// Ports:
//   clk_in    in   clock, rising edge
//   reset     in   asynchronous, active-high
//   go        in   burst accept strobe from the top FSM (one cycle)
//   kill      in   abort strobe, clears the channel at the next edge
//   en        in   channel enable, sampled on go
//   delay     in   start delay in clk_in cycles, sampled on go
//   burst_len in   carrier periods N, sampled on go
//   pin       out  registered pin drive
//   finished  out  high when idle or when this channel's burst is complete
module tx_burst_channel #(
   parameter int HALF_PERIOD = 625,
   parameter int BURST_W     = 8,
   parameter int DELAY_W     = 10
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               go,
   input  logic               kill,
   input  logic               en,
   input  logic [DELAY_W-1:0] delay,
   input  logic [BURST_W-1:0] burst_len,
   output logic               pin,
   output logic               finished
);

   localparam int HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

   logic               r_wait;   // counting down the start delay
   logic               r_run;    // emitting carrier periods
   logic               r_pin;    // pin level doubles as the carrier phase
   logic [DELAY_W-1:0] r_dly;
   logic [HP_W-1:0]    r_hp;
   logic [BURST_W-1:0] r_per;    // periods still to emit, including the current one

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_wait <= 1'b0;
         r_run  <= 1'b0;
         r_pin  <= 1'b0;
         r_dly  <= '0;
         r_hp   <= '0;
         r_per  <= '0;
      end else if (kill) begin
         r_wait <= 1'b0;
         r_run  <= 1'b0;
         r_pin  <= 1'b0;
         r_dly  <= '0;
         r_hp   <= '0;
         r_per  <= '0;
      end else if (go) begin
         r_hp  <= '0;
         r_per <= burst_len;
         r_dly <= '0;
         r_wait <= 1'b0;
         r_run  <= 1'b0;
         r_pin  <= 1'b0;
         if (en && (burst_len != '0)) begin
            if (delay == '0) begin
               // Zero delay: the pin rises on the accept edge itself.
               r_run <= 1'b1;
               r_pin <= 1'b1;
            end else begin
               r_wait <= 1'b1;
               r_dly  <= delay;
            end
         end
      end else if (r_wait) begin
         r_dly <= r_dly - DELAY_W'(1);
         // Launch on the edge where the remaining delay reaches one, so the
         // pin rises exactly 'delay' edges after the accept edge.
         if (r_dly == DELAY_W'(1)) begin
            r_wait <= 1'b0;
            r_run  <= 1'b1;
            r_pin  <= 1'b1;
            r_hp   <= '0;
         end
      end else if (r_run) begin
         if (r_hp == HP_LAST) begin
            r_hp <= '0;
            if (r_pin) begin
               r_pin <= 1'b0;
            end else if (r_per == BURST_W'(1)) begin
               // End of the low half of the last period: burst complete.
               r_run <= 1'b0;
               r_per <= '0;
            end else begin
               r_per <= r_per - BURST_W'(1);
               r_pin <= 1'b1;
            end
         end else begin
            r_hp <= r_hp + HP_W'(1);
         end
      end
   end

   assign pin      = r_pin;
   assign finished = !r_wait && !r_run;

endmodule

// File: rtl/transmitter_burst_driver.sv
// Multi-channel ultrasonic transmitter driver. On an accepted start it emits a
// burst of burst_len carrier periods on every enabled pin, each channel offset
// by its own delay for beam steering.
// Ports:
//   clk_in          in   clock, rising edge
//   reset           in   asynchronous, active-high
//   start           in   burst request, honoured only in IDLE and without abort
//   abort           in   synchronous cancel of a running burst
//   burst_len       in   carrier periods per burst (N)
//   ch_enable       in   per-channel enable
//   ch_delay        in   channel i delay = ch_delay[i*DELAY_W +: DELAY_W]
//   transmitter_pin out  registered pin drive
//   busy            out  high while in RUN
//   done            out  one-cycle pulse after a burst completes normally
//   dbg_state       out  current FSM state (state_t encoding)
module transmitter_burst_driver
   import transmitter_burst_driver_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int HALF_PERIOD = TX_HALF_PERIOD_50M,
   parameter int BURST_W     = 8,
   parameter int DELAY_W     = 10
) (
   input  logic                      clk_in,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [BURST_W-1:0]        burst_len,
   input  logic [NUM_CH-1:0]         ch_enable,
   input  logic [NUM_CH*DELAY_W-1:0] ch_delay,
   output logic [NUM_CH-1:0]         transmitter_pin,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                dbg_state
);

   state_t            r_state;
   state_t            w_next;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;
   logic              w_kill;
   logic              w_all_fin;
   logic [NUM_CH-1:0] w_fin;
   logic [NUM_CH-1:0] w_pin;

   // FSM handshake: start is a level request consumed on the edge where the
   // FSM is IDLE and abort is low; it is not queued otherwise. abort acts only
   // in RUN and always beats completion on the same edge.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_kill   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_next   = ST_RUN;
               w_accept = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_next = ST_IDLE;
               w_kill = 1'b1;
            end else if (w_all_fin) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == ST_RUN);
         r_done  <= (w_next == ST_DONE);
      end
   end

   // The accept strobe is the input latch: each channel captures its enable,
   // delay and burst_len on that edge, so later input changes are ignored.
   // A zero-delay channel must raise its pin on that same edge, which is why
   // the capture lives in the channel rather than in a separate top register.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tx_burst_channel #(
         .HALF_PERIOD (HALF_PERIOD),
         .BURST_W     (BURST_W),
         .DELAY_W     (DELAY_W)
      ) u_ch (
         .clk_in    (clk_in),
         .reset     (reset),
         .go        (w_accept),
         .kill      (w_kill),
         .en        (ch_enable[g]),
         .delay     (ch_delay[g*DELAY_W +: DELAY_W]),
         .burst_len (burst_len),
         .pin       (w_pin[g]),
         .finished  (w_fin[g])
      );
   end

   assign w_all_fin       = &w_fin;
   assign transmitter_pin = w_pin;
   assign busy            = r_busy;
   assign done            = r_done;
   assign dbg_state       = r_state;

endmodule
